unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the IF stage (instruction fetch) and the
//  MEM stage (load/store). Grants one requester at a time, holds the memory request until
//  the memory acks, returns data, and drives per-stage stall lines to freeze the pipeline.
//  Sits between IF_STAGE/MEM_STAGE and the memory; the hazard/flush logic consumes the stalls.
// PARAMETERS
//  DATA_W       32   data/address width
//  MAX_IF_WAIT  4    consecutive DM grants while IF waits before IF is forced to win once
//  TIMEOUT      255  cycles in a SERVE state without Mem_Ack before abort (8-bit counter)
// PORTS
//  Clock        in   1       single clock, rising edge
//  Reset        in   1       asynchronous, active-low; all state cleared while low
//  IF_Req       in   1       fetch request; held with IF_Addr stable until IF_Valid
//  IF_Addr      in   32      fetch address
//  IF_Valid     out  1       one-cycle pulse: IF_RData valid, request retired
//  IF_RData     out  32      fetched instruction (registered)
//  DM_Req       in   1       data request (MemRead|MemWrite); held stable until DM_Valid
//  DM_Write     in   1       1 = store, 0 = load
//  DM_Addr      in   32      data address
//  DM_WData     in   32      store data
//  DM_ByteEn    in   4       store byte enables
//  DM_Valid     out  1       one-cycle pulse: load data valid / store done
//  DM_RData     out  32      load data (registered); 0 after a store
//  Stall_IF     out  1       IF_Req & ~IF_Valid (combinational)
//  Stall_MEM    out  1       DM_Req & ~DM_Valid (combinational)
//  Mem_Req      out  1       memory request, held until Mem_Ack
//  Mem_We       out  1       memory write enable
//  Mem_Addr     out  32      memory address (registered at grant)
//  Mem_WData    out  32      memory write data (registered at grant)
//  Mem_BE       out  4       byte enables; 4'b1111 for fetch and loads
//  Mem_RData    in   32      memory read data, valid with Mem_Ack
//  Mem_Ack      in   1       one-cycle completion strobe
//  Err_Timeout  out  1       sticky; set on any timeout abort, cleared only by Reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; starve/timeout counters 0. Async assert drops Mem_Req
//   immediately; an in-flight access is abandoned and never reported Valid.
//  FSM states IDLE, SERVE_IF, SERVE_DM.
//  IDLE: DM_Req only -> SERVE_DM; IF_Req only -> SERVE_IF; both -> SERVE_DM unless
//   starve==MAX_IF_WAIT, then SERVE_IF. Grant edge latches Addr/WData/BE/We into Mem_* regs.
//   Neither -> stay IDLE, Mem_Req=0.
//  starve: +1 on each DM grant while IF_Req high, saturates at MAX_IF_WAIT; 0 on IF grant.
//  SERVE_x: Mem_Req=1. On Mem_Ack: capture Mem_RData into x_RData, pulse x_Valid next cycle,
//   return to IDLE. Best-case latency req->Valid = 2 cycles (grant edge, ack edge).
//  A requester is never re-granted in the cycle its Valid pulses (Valid cycle is IDLE with
//   the retired request still visible); requester must drop or change Req after Valid.
//  Timeout counter: 0 on entering SERVE, +1 per cycle without ack. At TIMEOUT: Mem_Req
//   drops, x_Valid pulses with x_RData=32'hDEAD_BEEF, Err_Timeout<=1, state IDLE.
//  Ack in the same cycle the counter reaches TIMEOUT: ack wins, normal completion.
//  Mem_Ack while IDLE: ignored.
//  Req deasserted mid-SERVE: access still completes to memory; no Valid is lost or suppressed.
// TESTING
//  IF_Req only, addr 0x40, Mem_Ack 1 cycle after Mem_Req, RData 0x2002_0005 -> IF_Valid at
//   cycle 2, IF_RData=0x2002_0005, Stall_IF high cycles 0-1 only.
//  IF_Req & DM_Req (load 0x100) together -> DM served first, then IF; Mem_BE=4'hF both.
//  DM store addr 0x200 data 0xCAFE_F00D BE=4'b0011 -> Mem_We=1, Mem_BE=0011, DM_RData=0.
//  IF_Req held, DM_Req re-raised after each DM_Valid -> IF granted after exactly 4 DM grants.
//  Never ack -> after 255 SERVE cycles Valid pulses with 0xDEAD_BEEF, Err_Timeout=1 sticky.
//  Reset low mid-SERVE_DM -> Mem_Req=0 same cycle, no DM_Valid, state IDLE after release.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between
// instruction fetch and data access, with starvation guard and timeout.
module unified_mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int MAX_IF_WAIT = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IF_Req,
    input  logic [DATA_W-1:0] IF_Addr,
    output logic              IF_Valid,
    output logic [DATA_W-1:0] IF_RData,
    input  logic              DM_Req,
    input  logic              DM_Write,
    input  logic [DATA_W-1:0] DM_Addr,
    input  logic [DATA_W-1:0] DM_WData,
    input  logic [3:0]        DM_ByteEn,
    output logic              DM_Valid,
    output logic [DATA_W-1:0] DM_RData,
    output logic              Stall_IF,
    output logic              Stall_MEM,
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [DATA_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    output logic [3:0]        Mem_BE,
    input  logic [DATA_W-1:0] Mem_RData,
    input  logic              Mem_Ack,
    output logic              Err_Timeout
);

    localparam int SW = $clog2(MAX_IF_WAIT + 1);
    localparam logic [DATA_W-1:0] POISON = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_IF,
        SERVE_DM
    } state_t;

    state_t        state;
    state_t        next;
    logic [SW-1:0] starve;
    logic [7:0]    tcnt;

    logic turn;
    logic if_pend;
    logic dm_pend;
    logic grant_if;
    logic grant_dm;
    logic idle;
    logic tmo_hit;
    logic done;

    // A cycle with any Valid pulse is a turnaround cycle: the retired
    // request is still visible, so nothing is granted in it.
    assign turn     = IF_Valid | DM_Valid;
    assign if_pend  = IF_Req & ~turn;
    assign dm_pend  = DM_Req & ~turn;
    assign idle     = (state == IDLE);
    assign grant_dm = idle & dm_pend &
                      ~(if_pend & (starve == SW'(MAX_IF_WAIT)));
    assign grant_if = idle & if_pend & ~grant_dm;
    assign tmo_hit  = ~idle & ~Mem_Ack & (tcnt == 8'(TIMEOUT - 1));
    assign done     = ~idle & (Mem_Ack | tmo_hit);

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= next;
    end

    // Next-state: grant from IDLE, return on ack or timeout
    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (grant_dm)      next = SERVE_DM;
                else if (grant_if) next = SERVE_IF;
            end
            SERVE_IF, SERVE_DM: begin
                if (done) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Outputs decoded from state; Mem_Req drops with async reset
    always_comb begin
        Mem_Req   = (state != IDLE);
        Stall_IF  = IF_Req & ~IF_Valid;
        Stall_MEM = DM_Req & ~DM_Valid;
    end

    // Grant-time latching of the memory command and completion capture
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Mem_We      <= 1'b0;
            Mem_Addr    <= '0;
            Mem_WData   <= '0;
            Mem_BE      <= 4'h0;
            IF_Valid    <= 1'b0;
            IF_RData    <= '0;
            DM_Valid    <= 1'b0;
            DM_RData    <= '0;
            Err_Timeout <= 1'b0;
        end else begin
            IF_Valid <= 1'b0;
            DM_Valid <= 1'b0;
            if (grant_dm) begin
                Mem_We    <= DM_Write;
                Mem_Addr  <= DM_Addr;
                Mem_WData <= DM_WData;
                Mem_BE    <= DM_Write ? DM_ByteEn : 4'hF;
            end else if (grant_if) begin
                Mem_We    <= 1'b0;
                Mem_Addr  <= IF_Addr;
                Mem_WData <= '0;
                Mem_BE    <= 4'hF;
            end
            if (done && state == SERVE_IF) begin
                IF_Valid <= 1'b1;
                IF_RData <= Mem_Ack ? Mem_RData : POISON;
            end
            if (done && state == SERVE_DM) begin
                DM_Valid <= 1'b1;
                if (!Mem_Ack)    DM_RData <= POISON;
                else if (Mem_We) DM_RData <= '0;
                else             DM_RData <= Mem_RData;
            end
            if (tmo_hit) Err_Timeout <= 1'b1;
        end
    end

    // Fairness and timeout counters
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            starve <= '0;
            tcnt   <= 8'd0;
        end else begin
            if (grant_if) begin
                starve <= '0;
            end else if (grant_dm && if_pend &&
                         starve != SW'(MAX_IF_WAIT)) begin
                starve <= starve + SW'(1);
            end
            if (idle)          tcnt <= 8'd0;
            else if (!Mem_Ack) tcnt <= tcnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_unified_mem_arbiter;

    logic        Clock;
    logic        Reset;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic        IF_Valid;
    logic [31:0] IF_RData;
    logic        DM_Req;
    logic        DM_Write;
    logic [31:0] DM_Addr;
    logic [31:0] DM_WData;
    logic [3:0]  DM_ByteEn;
    logic        DM_Valid;
    logic [31:0] DM_RData;
    logic        Stall_IF;
    logic        Stall_MEM;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [3:0]  Mem_BE;
    logic [31:0] Mem_RData;
    logic        Mem_Ack;
    logic        Err_Timeout;

    int errors = 0;
    int checks = 0;

    unified_mem_arbiter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IF_Req      (IF_Req),
        .IF_Addr     (IF_Addr),
        .IF_Valid    (IF_Valid),
        .IF_RData    (IF_RData),
        .DM_Req      (DM_Req),
        .DM_Write    (DM_Write),
        .DM_Addr     (DM_Addr),
        .DM_WData    (DM_WData),
        .DM_ByteEn   (DM_ByteEn),
        .DM_Valid    (DM_Valid),
        .DM_RData    (DM_RData),
        .Stall_IF    (Stall_IF),
        .Stall_MEM   (Stall_MEM),
        .Mem_Req     (Mem_Req),
        .Mem_We      (Mem_We),
        .Mem_Addr    (Mem_Addr),
        .Mem_WData   (Mem_WData),
        .Mem_BE      (Mem_BE),
        .Mem_RData   (Mem_RData),
        .Mem_Ack     (Mem_Ack),
        .Err_Timeout (Err_Timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        IF_Req = 0; IF_Addr = 0;
        DM_Req = 0; DM_Write = 0; DM_Addr = 0; DM_WData = 0; DM_ByteEn = 0;
        Mem_RData = 0; Mem_Ack = 0;
        tick(); tick();
        chk("rst_mem_req", {31'd0, Mem_Req}, 0);
        chk("rst_if_valid", {31'd0, IF_Valid}, 0);
        chk("rst_dm_valid", {31'd0, DM_Valid}, 0);
        chk("rst_err", {31'd0, Err_Timeout}, 0);
        chk("rst_mem_addr", Mem_Addr, 0);
        chk("rst_mem_be", {28'd0, Mem_BE}, 0);
        Reset = 1'b1;
        tick();

        // Fetch only: Valid two cycles after request
        IF_Req = 1; IF_Addr = 32'h40;
        #1;
        chk("f_c0_stall", {31'd0, Stall_IF}, 1);
        chk("f_c0_req", {31'd0, Mem_Req}, 0);
        tick();
        chk("f_c1_req", {31'd0, Mem_Req}, 1);
        chk("f_c1_addr", Mem_Addr, 32'h40);
        chk("f_c1_be", {28'd0, Mem_BE}, 4'hF);
        chk("f_c1_we", {31'd0, Mem_We}, 0);
        chk("f_c1_stall", {31'd0, Stall_IF}, 1);
        Mem_Ack = 1; Mem_RData = 32'h2002_0005;
        tick();
        Mem_Ack = 0;
        chk("f_c2_valid", {31'd0, IF_Valid}, 1);
        chk("f_c2_rdata", IF_RData, 32'h2002_0005);
        chk("f_c2_stall", {31'd0, Stall_IF}, 0);
        chk("f_c2_req", {31'd0, Mem_Req}, 0);
        IF_Req = 0;
        tick();
        chk("f_c3_valid", {31'd0, IF_Valid}, 0);

        // Simultaneous: DM first, then IF
        IF_Req = 1; IF_Addr = 32'h44;
        DM_Req = 1; DM_Write = 0; DM_Addr = 32'h100;
        tick();
        chk("b_dm_addr", Mem_Addr, 32'h100);
        chk("b_dm_be", {28'd0, Mem_BE}, 4'hF);
        chk("b_dm_we", {31'd0, Mem_We}, 0);
        chk("b_stall_if", {31'd0, Stall_IF}, 1);
        chk("b_stall_mem", {31'd0, Stall_MEM}, 1);
        Mem_Ack = 1; Mem_RData = 32'h1111_2222;
        tick();
        Mem_Ack = 0;
        chk("b_dm_valid", {31'd0, DM_Valid}, 1);
        chk("b_dm_rdata", DM_RData, 32'h1111_2222);
        chk("b_if_valid", {31'd0, IF_Valid}, 0);
        chk("b_turn_req", {31'd0, Mem_Req}, 0);
        DM_Req = 0;
        tick();
        chk("b_idle_req", {31'd0, Mem_Req}, 0);
        tick();
        chk("b_if_req", {31'd0, Mem_Req}, 1);
        chk("b_if_addr", Mem_Addr, 32'h44);
        chk("b_if_be", {28'd0, Mem_BE}, 4'hF);
        Mem_Ack = 1; Mem_RData = 32'h3333_4444;
        tick();
        Mem_Ack = 0;
        chk("b_if_valid2", {31'd0, IF_Valid}, 1);
        chk("b_if_rdata", IF_RData, 32'h3333_4444);
        IF_Req = 0;
        tick();

        // Store
        DM_Req = 1; DM_Write = 1; DM_Addr = 32'h200;
        DM_WData = 32'hCAFE_F00D; DM_ByteEn = 4'b0011;
        tick();
        chk("s_req", {31'd0, Mem_Req}, 1);
        chk("s_we", {31'd0, Mem_We}, 1);
        chk("s_be", {28'd0, Mem_BE}, 4'b0011);
        chk("s_addr", Mem_Addr, 32'h200);
        chk("s_wdata", Mem_WData, 32'hCAFE_F00D);
        Mem_Ack = 1; Mem_RData = 32'h5555_5555;
        tick();
        Mem_Ack = 0;
        chk("s_valid", {31'd0, DM_Valid}, 1);
        chk("s_rdata", DM_RData, 0);
        DM_Req = 0; DM_Write = 0; DM_ByteEn = 0;
        tick();

        // Ack while idle is ignored
        Mem_Ack = 1; Mem_RData = 32'h9999_9999;
        tick();
        Mem_Ack = 0;
        chk("ia_if_valid", {31'd0, IF_Valid}, 0);
        chk("ia_dm_valid", {31'd0, DM_Valid}, 0);
        chk("ia_req", {31'd0, Mem_Req}, 0);

        // Starvation guard: IF wins after 4 DM grants
        IF_Req = 1; IF_Addr = 32'h80;
        for (int k = 0; k < 5; k++) begin
            DM_Req = 1; DM_Write = 0; DM_Addr = 32'h300 + 32'(4 * k);
            tick();
            if (k < 4) chk($sformatf("sv_dm%0d", k), Mem_Addr,
                           32'h300 + 32'(4 * k));
            else       chk("sv_if", Mem_Addr, 32'h80);
            Mem_Ack = 1; Mem_RData = 32'h7000_0000 + 32'(k);
            tick();
            Mem_Ack = 0;
            if (k < 4) begin
                chk($sformatf("sv_v%0d", k), {31'd0, DM_Valid}, 1);
                DM_Req = 0;
                tick();
            end
        end
        chk("sv_if_valid", {31'd0, IF_Valid}, 1);
        chk("sv_if_rdata", IF_RData, 32'h7000_0004);
        IF_Req = 0;
        tick();
        tick();
        chk("sv_dm_addr", Mem_Addr, 32'h310);
        chk("sv_dm_req", {31'd0, Mem_Req}, 1);

        // Timeout on this DM load: never ack
        for (int i = 0; i < 254; i++) tick();
        chk("to_still_req", {31'd0, Mem_Req}, 1);
        chk("to_no_valid", {31'd0, DM_Valid}, 0);
        chk("to_no_err", {31'd0, Err_Timeout}, 0);
        tick();
        chk("to_valid", {31'd0, DM_Valid}, 1);
        chk("to_rdata", DM_RData, 32'hDEAD_BEEF);
        chk("to_err", {31'd0, Err_Timeout}, 1);
        chk("to_req", {31'd0, Mem_Req}, 0);
        DM_Req = 0;
        tick();
        chk("to_err_sticky", {31'd0, Err_Timeout}, 1);

        // Ack in the last allowed cycle wins over timeout
        IF_Req = 1; IF_Addr = 32'h88;
        tick();
        for (int i = 0; i < 254; i++) tick();
        chk("al_req", {31'd0, Mem_Req}, 1);
        Mem_Ack = 1; Mem_RData = 32'h1234_5678;
        tick();
        Mem_Ack = 0;
        chk("al_valid", {31'd0, IF_Valid}, 1);
        chk("al_rdata", IF_RData, 32'h1234_5678);
        IF_Req = 0;
        tick();

        // Reset mid-SERVE_DM
        DM_Req = 1; DM_Write = 0; DM_Addr = 32'h400;
        tick();
        chk("r_req_before", {31'd0, Mem_Req}, 1);
        #2 Reset = 1'b0;
        #1;
        chk("r_req_async", {31'd0, Mem_Req}, 0);
        chk("r_err_clr", {31'd0, Err_Timeout}, 0);
        tick();
        Reset = 1'b1;
        DM_Req = 0;
        tick();
        chk("r_no_valid", {31'd0, DM_Valid}, 0);
        chk("r_req_after", {31'd0, Mem_Req}, 0);
        chk("r_addr_clr", Mem_Addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
